// File: rtl/serdes_tx_arbiter.sv
// serdes_tx_arbiter: round-robin packet arbiter and framer feeding a shared SERDES transmit pipeline
module serdes_tx_arbiter #(
    parameter int          MAX_LEN  = 256,
    parameter int          LEN_W    = 9,
    parameter logic [15:0] SOP_WORD = 16'h5C5C,
    parameter logic [15:0] EOP_WORD = 16'hFDFD
) (
    input  logic        dsp_clk,
    input  logic        dsp_rst,
    input  logic [15:0] req0_dat,
    input  logic        req0_valid,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic [15:0] req1_dat,
    input  logic        req1_valid,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic [15:0] tx_dat_o,
    output logic        tx_klsb_o,
    output logic        tx_kmsb_o,
    output logic        tx_en,
    input  logic        tx_rdy,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        pkt_done,
    output logic        trunc_err
);
    typedef enum logic [2:0] {IDLE, SOP, DATA, CSUM, EOP, DROP} state_t;
    state_t           state;
    logic             last_grant;
    logic             drop_pending;
    logic [LEN_W-1:0] cnt;
    logic [15:0]      csum;
    logic             sel;
    logic             g_valid;
    logic             g_last;
    logic [15:0]      g_dat;
    logic             at_max;
    logic             pick;
    logic             take;
    // Mux the granted requester and derive the handshake, framing word and event pulses
    always_comb begin
        sel        = grant[1];
        g_valid    = sel ? req1_valid : req0_valid;
        g_last     = sel ? req1_last : req0_last;
        g_dat      = sel ? req1_dat : req0_dat;
        at_max     = cnt == LEN_W'(MAX_LEN - 1);
        pick       = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        take       = (state == DATA & tx_rdy) | state == DROP;
        req0_ready = grant[0] & take;
        req1_ready = grant[1] & take;
        tx_en      = (state == SOP || state == CSUM || state == EOP) ? tx_rdy :
                     state == DATA ? tx_rdy & g_valid : 1'b0;
        tx_dat_o   = state == SOP  ? SOP_WORD :
                     state == DATA ? g_dat :
                     state == CSUM ? csum :
                     state == EOP  ? EOP_WORD : 16'h0000;
        tx_klsb_o  = state == SOP || state == EOP;
        tx_kmsb_o  = state == SOP || state == EOP;
        busy       = state != IDLE;
        pkt_done   = state == EOP & tx_rdy;
        trunc_err  = state == DATA & tx_en & ~g_last & at_max;
    end
    // Packet FSM: arbitrate in IDLE, frame SOP/payload/checksum/EOP, then discard any truncated tail
    always_ff @(posedge dsp_clk) begin
        if (dsp_rst) begin
            state        <= IDLE;
            grant        <= 2'b00;
            last_grant   <= 1'b1;
            cnt          <= '0;
            csum         <= 16'h0000;
            drop_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_valid | req1_valid) begin
                    grant      <= pick ? 2'b10 : 2'b01;
                    last_grant <= pick;
                    cnt        <= '0;
                    csum       <= 16'h0000;
                    state      <= SOP;
                end
                SOP: if (tx_rdy) state <= DATA;
                DATA: if (tx_en) begin
                    csum <= csum + g_dat;
                    cnt  <= cnt + 1'b1;
                    if (g_last) state <= CSUM;
                    else if (at_max) begin
                        state        <= CSUM;
                        drop_pending <= 1'b1;
                    end
                end
                CSUM: if (tx_rdy) state <= EOP;
                EOP: if (tx_rdy) begin
                    state <= drop_pending ? DROP : IDLE;
                    if (!drop_pending) grant <= 2'b00;
                end
                DROP: if (g_valid & g_last) begin
                    drop_pending <= 1'b0;
                    grant        <= 2'b00;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// tb_serdes_tx_arbiter: randomized scoreboard bench for the packet arbiter/framer
module tb_serdes_tx_arbiter;
    localparam int          MAX_LEN = 4;
    localparam logic [15:0] SOP_W   = 16'h5C5C;
    localparam logic [15:0] EOP_W   = 16'hFDFD;

    logic        dsp_clk = 1'b0;
    logic        dsp_rst = 1'b1;
    logic [15:0] req0_dat = '0, req1_dat = '0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_last = 1'b0, req1_last = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] tx_dat_o;
    logic        tx_klsb_o, tx_kmsb_o, tx_en;
    logic        tx_rdy = 1'b1;
    logic [1:0]  grant;
    logic        busy, pkt_done, trunc_err;

    serdes_tx_arbiter #(.MAX_LEN(MAX_LEN), .LEN_W(3), .SOP_WORD(SOP_W), .EOP_WORD(EOP_W)) dut (
        .dsp_clk(dsp_clk), .dsp_rst(dsp_rst),
        .req0_dat(req0_dat), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_dat(req1_dat), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_dat_o(tx_dat_o), .tx_klsb_o(tx_klsb_o), .tx_kmsb_o(tx_kmsb_o), .tx_en(tx_en), .tx_rdy(tx_rdy),
        .grant(grant), .busy(busy), .pkt_done(pkt_done), .trunc_err(trunc_err)
    );

    always #5 dsp_clk = ~dsp_clk;

    logic [16:0] src0[$], src1[$];
    logic [16:0] exp0[$], exp1[$];
    int          grant_log[$];
    int checks = 0, errors = 0;
    int exp_pkts = 0, obs_pkts = 0, exp_trunc = 0, obs_trunc = 0;
    int cyc = 0, sop_cyc = 0, p1_cyc = 0, pay_cnt = 0, open_port = 0;
    int rdy_mode = 0;
    bit gaps = 1'b0;

    always @(posedge dsp_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic push_exp(input int p, input logic [16:0] v);
        if (p == 0) exp0.push_back(v);
        else exp1.push_back(v);
    endtask

    // Reference model: a packet becomes SOP, up to MAX_LEN payload words, their 16-bit sum, EOP
    task automatic send(input int p, input logic [15:0] w[$]);
        logic [15:0] sum;
        int kept;
        sum  = 16'h0000;
        kept = (w.size() > MAX_LEN) ? MAX_LEN : w.size();
        for (int i = 0; i < w.size(); i++) begin
            if (p == 0) src0.push_back({i == w.size() - 1, w[i]});
            else src1.push_back({i == w.size() - 1, w[i]});
        end
        push_exp(p, {1'b1, SOP_W});
        for (int i = 0; i < kept; i++) begin
            push_exp(p, {1'b0, w[i]});
            sum = sum + w[i];
        end
        push_exp(p, {1'b0, sum});
        push_exp(p, {1'b1, EOP_W});
        exp_pkts++;
        if (w.size() > MAX_LEN) exp_trunc++;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 && n < limit) begin
            @(posedge dsp_clk);
            n++;
        end
        chk("drain_done", n < limit, 1);
        repeat (3) @(posedge dsp_clk);
        @(negedge dsp_clk);
        #4;
        chk("idle_after_drain", busy, 0);
    endtask

    // Drivers: present queued words on both ports and pace tx_rdy; pop a word on each handshake
    initial begin
        forever begin
            @(negedge dsp_clk);
            tx_rdy     = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~tx_rdy : ($urandom % 3 != 0);
            req0_valid = src0.size() > 0 && (!gaps || $urandom % 4 != 0);
            req1_valid = src1.size() > 0 && (!gaps || $urandom % 4 != 0);
            req0_dat   = src0.size() > 0 ? src0[0][15:0] : 16'($urandom);
            req1_dat   = src1.size() > 0 ? src1[0][15:0] : 16'($urandom);
            req0_last  = src0.size() > 0 ? src0[0][16] : 1'b0;
            req1_last  = src1.size() > 0 ? src1[0][16] : 1'b0;
            #2;
            if (req0_valid && req0_ready) void'(src0.pop_front());
            if (req1_valid && req1_ready) void'(src1.pop_front());
        end
    end

    // Monitor: on every enqueue, pop the granted port's expected word and compare
    initial begin
        logic [16:0] e;
        int p;
        forever begin
            @(negedge dsp_clk);
            #3;
            if (pkt_done) obs_pkts++;
            if (trunc_err) obs_trunc++;
            chk("busy_vs_grant", busy, grant != 2'b00);
            chk("ready0_ungranted", req0_ready & ~grant[0], 0);
            chk("ready1_ungranted", req1_ready & ~grant[1], 0);
            if (!tx_en) chk("pkt_done_without_tx_en", pkt_done, 0);
            if (tx_en) begin
                chk("tx_en_while_not_rdy", tx_rdy, 1);
                chk("grant_onehot", grant == 2'b01 || grant == 2'b10, 1);
                p = grant[1] ? 1 : 0;
                if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word port %0d got %h want nothing", p, tx_dat_o);
                end else begin
                    e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
                    chk("tx_word", {tx_klsb_o, tx_kmsb_o, tx_dat_o}, {e[16], e[16], e[15:0]});
                    chk("pkt_done_on_eop", pkt_done, e == {1'b1, EOP_W});
                    if (e == {1'b1, SOP_W}) begin
                        grant_log.push_back(p);
                        open_port = p;
                        pay_cnt   = 0;
                        sop_cyc   = cyc;
                    end else begin
                        chk("no_interleave", p, open_port);
                        pay_cnt++;
                        if (pay_cnt == 1) p1_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[$];
        int k, n, t0;
        repeat (3) @(posedge dsp_clk);
        #1 dsp_rst = 1'b0;
        @(negedge dsp_clk);
        #4;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_dat_k", {tx_klsb_o, tx_kmsb_o, tx_dat_o}, 0);
        chk("rst_pulses", {pkt_done, trunc_err}, 0);

        // Single packet on port 0, with SOP/first-payload latency
        @(posedge dsp_clk);
        #1 k = cyc;
        w.delete(); w.push_back(16'h0001); w.push_back(16'h0002); w.push_back(16'h0003);
        send(0, w);
        drain(200);
        chk("sop_latency", sop_cyc - k, 1);
        chk("payload_latency", p1_cyc - k, 2);
        chk("single_pkt_done", obs_pkts, 1);

        // Checksum wrap on port 1 (leaves port 1 as last granted)
        w.delete(); w.push_back(16'hFFFF); w.push_back(16'h0002);
        send(1, w);
        drain(200);

        // Round-robin with both ports continuously requesting
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            w.delete(); w.push_back(16'(16'h0100 * (i + 1))); w.push_back(16'(16'h0011 * (i + 1)));
            send(i / 2, w);
        end
        drain(400);
        chk("rr_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) chk("rr_order", grant_log[i], i % 2);

        // Backpressure: tx_rdy toggles each cycle
        rdy_mode = 1;
        w.delete(); w.push_back(16'hA001); w.push_back(16'hB002); w.push_back(16'hC003); w.push_back(16'hD004);
        send(0, w);
        drain(400);
        rdy_mode = 0;

        // Truncation: 6 words on port 1 with MAX_LEN = 4
        t0 = obs_trunc;
        w.delete();
        for (int i = 0; i < 6; i++) w.push_back(16'(16'h1000 + i));
        send(1, w);
        drain(400);
        chk("trunc_once", obs_trunc - t0, 1);

        // Randomized traffic: random ports, lengths (some truncating), gaps and backpressure
        rdy_mode = 2;
        gaps = 1'b1;
        for (int j = 0; j < 40; j++) begin
            n = $urandom_range(1, 6);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(($urandom % 5 == 0) ? 16'hFFFF : 16'($urandom));
            send($urandom % 2, w);
        end
        drain(8000);
        rdy_mode = 0;
        gaps = 1'b0;
        chk("pkt_count", obs_pkts, exp_pkts);
        chk("trunc_count", obs_trunc, exp_trunc);

        // Reset mid-packet after the second payload word
        w.delete(); w.push_back(16'h0101); w.push_back(16'h0202); w.push_back(16'h0303); w.push_back(16'h0404);
        send(0, w);
        n = 0;
        do begin
            @(negedge dsp_clk);
            #4;
            n++;
        end while (pay_cnt < 2 && n < 100);
        chk("reach_second_word", n < 100, 1);
        dsp_rst = 1'b1;
        src0.delete();
        exp0.delete();
        exp_pkts--;
        @(posedge dsp_clk);
        #1 dsp_rst = 1'b0;
        @(negedge dsp_clk);
        #4;
        chk("midrst_tx_en", tx_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_grant", grant, 0);
        w.delete(); w.push_back(16'h0010); w.push_back(16'h0020);
        send(0, w);
        drain(200);

        chk("pkt_count_final", obs_pkts, exp_pkts);
        chk("trunc_count_final", obs_trunc, exp_trunc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
